// File: rtl/mem_arbiter.sv
// Two-port (CPU / DMA) arbiter for a single shared data memory, one access outstanding at a time.
// Define ARB_ROUND_ROBIN_EN for alternating tie-break; default build gives the CPU fixed priority.
module mem_arbiter #(
    parameter int AW     = 64,
    parameter int DW     = 64,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic          dma_gnt,
    output logic          dma_rvalid,
    output logic [DW-1:0] dma_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_wr,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, RDWAIT} state_t;

    localparam logic [2:0] LP_CNT_INIT = 3'(RD_LAT - 1);

    state_t        r_state;
    logic          r_owner;          // 0 = CPU, 1 = DMA
    logic [2:0]    r_cnt;
    logic [AW-1:0] r_addr;
    logic          r_cpu_gnt;
    logic          r_dma_gnt;
    logic          r_cpu_rvalid;
    logic          r_dma_rvalid;
    logic [DW-1:0] r_cpu_rdata;
    logic [DW-1:0] r_dma_rdata;
    logic          r_busy;
`ifdef ARB_ROUND_ROBIN_EN
    logic          r_prio_dma;
`endif

    logic          w_any_req;
    logic          w_pick_dma;
    logic          w_done;
    logic          w_we;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_wdata;

    assign w_any_req = cpu_req | dma_req;

`ifdef ARB_ROUND_ROBIN_EN
    assign w_pick_dma = dma_req & (~cpu_req | r_prio_dma);
`else
    assign w_pick_dma = dma_req & ~cpu_req;
`endif

    // The owner's request fields are only looked at while it is being granted.
    assign w_we    = r_owner ? dma_we    : cpu_we;
    assign w_addr  = r_owner ? dma_addr  : cpu_addr;
    assign w_wdata = r_owner ? dma_wdata : cpu_wdata;

    always_comb begin
        w_done = 1'b0;
        case (r_state)
            IDLE:    w_done = 1'b1;
            ISSUE:   w_done = w_we;
            RDWAIT:  w_done = (r_cnt == '0);
            default: w_done = 1'b0;
        endcase
    end

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wr    = 1'b0;
        case (r_state)
            ISSUE: begin
                mem_addr  = w_addr;
                mem_wdata = w_wdata;
                mem_wr    = w_we;
            end
            RDWAIT:  mem_addr = r_addr;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_owner      <= 1'b0;
            r_cnt        <= '0;
            r_addr       <= '0;
            r_cpu_gnt    <= 1'b0;
            r_dma_gnt    <= 1'b0;
            r_cpu_rvalid <= 1'b0;
            r_dma_rvalid <= 1'b0;
            r_cpu_rdata  <= '0;
            r_dma_rdata  <= '0;
            r_busy       <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            r_prio_dma   <= 1'b0;
`endif
        end else begin
            r_cpu_gnt    <= 1'b0;
            r_dma_gnt    <= 1'b0;
            r_cpu_rvalid <= 1'b0;
            r_dma_rvalid <= 1'b0;
            case (r_state)
                ISSUE: begin
                    if (!w_we) begin
                        r_addr  <= w_addr;
                        r_cnt   <= LP_CNT_INIT;
                        r_state <= RDWAIT;
                    end
                end
                RDWAIT: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 3'd1;
                    end else if (r_owner) begin
                        r_dma_rdata  <= mem_rdata;
                        r_dma_rvalid <= 1'b1;
                    end else begin
                        r_cpu_rdata  <= mem_rdata;
                        r_cpu_rvalid <= 1'b1;
                    end
                end
                default: ;
            endcase
            // Completion of an access and IDLE share one selection path, so back-to-back grants need no idle cycle.
            if (w_done) begin
                if (w_any_req) begin
                    r_state   <= ISSUE;
                    r_owner   <= w_pick_dma;
                    r_cpu_gnt <= ~w_pick_dma;
                    r_dma_gnt <= w_pick_dma;
                    r_busy    <= 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
                    r_prio_dma <= ~w_pick_dma;
`endif
                end else begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            end
        end
    end

    assign cpu_gnt    = r_cpu_gnt;
    assign dma_gnt    = r_dma_gnt;
    assign cpu_rvalid = r_cpu_rvalid;
    assign dma_rvalid = r_dma_rvalid;
    assign cpu_rdata  = r_cpu_rdata;
    assign dma_rdata  = r_dma_rdata;
    assign busy       = r_busy;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: RD_LAT=1 instance under a grant/read-data monitor, RD_LAT=3 instance for reset-abort.
module tb_mem_arbiter;

    localparam int AW = 64;
    localparam int DW = 64;
    localparam int RD_LAT = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          cpu_req, cpu_we, dma_req, dma_we;
    logic [AW-1:0] cpu_addr, dma_addr;
    logic [DW-1:0] cpu_wdata, dma_wdata;
    logic          cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid;
    logic [DW-1:0] cpu_rdata, dma_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          mem_wr, busy;

    mem_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) u_dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr(mem_wr), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    logic          l3_reset;
    logic          l3_cpu_req, l3_cpu_we, l3_dma_req, l3_dma_we;
    logic [AW-1:0] l3_cpu_addr, l3_dma_addr;
    logic [DW-1:0] l3_cpu_wdata, l3_dma_wdata;
    logic          l3_cpu_gnt, l3_cpu_rvalid, l3_dma_gnt, l3_dma_rvalid;
    logic [DW-1:0] l3_cpu_rdata, l3_dma_rdata;
    logic [AW-1:0] l3_mem_addr;
    logic [DW-1:0] l3_mem_wdata;
    logic [DW-1:0] l3_mem_rdata = 64'hABCD;
    logic          l3_mem_wr, l3_busy;

    mem_arbiter #(.AW(AW), .DW(DW), .RD_LAT(3)) u_dut_l3 (
        .clk(clk), .reset(l3_reset),
        .cpu_req(l3_cpu_req), .cpu_we(l3_cpu_we), .cpu_addr(l3_cpu_addr), .cpu_wdata(l3_cpu_wdata),
        .cpu_gnt(l3_cpu_gnt), .cpu_rvalid(l3_cpu_rvalid), .cpu_rdata(l3_cpu_rdata),
        .dma_req(l3_dma_req), .dma_we(l3_dma_we), .dma_addr(l3_dma_addr), .dma_wdata(l3_dma_wdata),
        .dma_gnt(l3_dma_gnt), .dma_rvalid(l3_dma_rvalid), .dma_rdata(l3_dma_rdata),
        .mem_addr(l3_mem_addr), .mem_wdata(l3_mem_wdata), .mem_wr(l3_mem_wr), .mem_rdata(l3_mem_rdata),
        .busy(l3_busy)
    );

    // Behavioural memory; address 0x20 preloaded with 0x1234.
    logic [DW-1:0] tb_mem [256];
    bit            mem_loaded = 1'b0;
    always @(posedge clk) begin
        if (!mem_loaded) begin
            tb_mem[8'h20] <= 64'h1234;
            mem_loaded    <= 1'b1;
        end else if (mem_wr) begin
            tb_mem[mem_addr[7:0]] <= mem_wdata;
        end
    end
    assign mem_rdata = tb_mem[mem_addr[7:0]];

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    typedef struct {
        bit          dma;
        bit          we;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] rdata;
        int          gap;     // required cycles since previous grant, -1 = don't care
    } gnt_t;
    typedef struct {
        bit          dma;
        logic [63:0] data;
        int          due;
    } rd_t;

    gnt_t exp_gnt[$];
    rd_t  pend[$];
    int   last_gnt_cyc = 0;
    int   n_dma_gnt = 0;

    function automatic void exp_push(bit dma, bit we, logic [63:0] a, logic [63:0] wd,
                                     logic [63:0] rd, int gap);
        gnt_t e;
        e.dma = dma; e.we = we; e.addr = a; e.wdata = wd; e.rdata = rd; e.gap = gap;
        exp_gnt.push_back(e);
    endfunction

    // Monitor: pops the scoreboard whenever the DUT grants or returns read data.
    always @(negedge clk) begin
        if (cpu_gnt || dma_gnt) begin
            gnt_t e;
            if (dma_gnt) n_dma_gnt++;
            chk("gnt_onehot", {62'd0, cpu_gnt, dma_gnt} & 64'h3, cpu_gnt ? 64'h2 : 64'h1);
            if (exp_gnt.size() == 0) begin
                chk("unexpected_gnt", {63'd0, dma_gnt}, 64'h2);
            end else begin
                e = exp_gnt.pop_front();
                chk("gnt_port", {63'd0, dma_gnt}, {63'd0, e.dma});
                chk("gnt_mem_addr", mem_addr, e.addr);
                chk("gnt_mem_wdata", mem_wdata, e.wdata);
                chk("gnt_mem_wr", {63'd0, mem_wr}, {63'd0, e.we});
                chk("gnt_busy", {63'd0, busy}, 64'd1);
                if (e.gap >= 0) chk("gnt_gap", 64'(cyc - last_gnt_cyc), 64'(e.gap));
                if (!e.we) begin
                    rd_t r;
                    r.dma = e.dma; r.data = e.rdata; r.due = cyc + RD_LAT + 1;
                    pend.push_back(r);
                end
            end
            last_gnt_cyc = cyc;
        end
        if (cpu_rvalid || dma_rvalid) begin
            rd_t r;
            if (cpu_rvalid && dma_rvalid) chk("rvalid_onehot", 64'd3, 64'd1);
            if (pend.size() == 0) begin
                chk("unexpected_rvalid", {63'd0, dma_rvalid}, 64'h2);
            end else begin
                r = pend.pop_front();
                chk("rvalid_port", {63'd0, dma_rvalid}, {63'd0, r.dma});
                chk("rvalid_latency", 64'(cyc), 64'(r.due));
                chk("rdata", r.dma ? dma_rdata : cpu_rdata, r.data);
            end
        end
    end

    task automatic cpu_access(input bit we, input logic [63:0] a, input logic [63:0] wd);
        bit got = 1'b0;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            got = cpu_gnt;
        end
        cpu_req = 1'b0;
        if (!got) chk("cpu_gnt_timeout", 64'd0, 64'd1);
    endtask

    task automatic dma_access(input bit we, input logic [63:0] a, input logic [63:0] wd);
        bit got = 1'b0;
        dma_req = 1'b1; dma_we = we; dma_addr = a; dma_wdata = wd;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            got = dma_gnt;
        end
        dma_req = 1'b0;
        if (!got) chk("dma_gnt_timeout", 64'd0, 64'd1);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int dma_before;
        int l3_gnt_cyc;
        bit got;

        reset = 1'b0; l3_reset = 1'b0;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
        l3_cpu_req = 0; l3_cpu_we = 0; l3_cpu_addr = '0; l3_cpu_wdata = '0;
        l3_dma_req = 0; l3_dma_we = 0; l3_dma_addr = '0; l3_dma_wdata = '0;
        idle_cycles(3);

        chk("rst_cpu_gnt", {63'd0, cpu_gnt}, 64'd0);
        chk("rst_dma_gnt", {63'd0, dma_gnt}, 64'd0);
        chk("rst_rvalid", {62'd0, cpu_rvalid, dma_rvalid}, 64'd0);
        chk("rst_mem_wr", {63'd0, mem_wr}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_mem_addr", mem_addr, 64'd0);
        chk("rst_mem_wdata", mem_wdata, 64'd0);
        chk("rst_cpu_rdata", cpu_rdata, 64'd0);
        chk("rst_dma_rdata", dma_rdata, 64'd0);
        reset = 1'b1;

        // CPU write 0x10 <- 0xDEAD, then back to idle
        exp_push(0, 1, 64'h10, 64'hDEAD, 64'h0, -1);
        @(posedge clk); #1;
        cpu_access(1, 64'h10, 64'hDEAD);
        @(negedge clk);
        chk("wr_busy_after", {63'd0, busy}, 64'd0);
        chk("idle_mem_addr", mem_addr, 64'd0);
        chk("idle_mem_wr", {63'd0, mem_wr}, 64'd0);

        // DMA read 0x20 -> 0x1234, held afterwards
        exp_push(1, 0, 64'h20, 64'h0, 64'h1234, -1);
        @(posedge clk); #1;
        dma_access(0, 64'h20, 64'h0);
        idle_cycles(6);
        chk("dma_rdata_hold", dma_rdata, 64'h1234);

        // CPU read-back of the earlier write
        exp_push(0, 0, 64'h10, 64'h0, 64'hDEAD, -1);
        @(posedge clk); #1;
        cpu_access(0, 64'h10, 64'h0);
        idle_cycles(5);
        chk("cpu_rdata_hold", cpu_rdata, 64'hDEAD);
        chk("dma_rdata_untouched", dma_rdata, 64'h1234);

        // CPU write then DMA read of the same word, back to back
        exp_push(0, 1, 64'h30, 64'hBEEF, 64'h0, -1);
        exp_push(1, 0, 64'h30, 64'h0, 64'hBEEF, 1);
        fork
            begin @(posedge clk); #1; cpu_access(1, 64'h30, 64'hBEEF); end
            begin @(posedge clk); @(posedge clk); #1; dma_access(0, 64'h30, 64'h0); end
        join
        idle_cycles(6);

        // DMA request raised during a CPU read and withdrawn before it could win
        exp_push(0, 0, 64'h20, 64'h0, 64'h1234, -1);
        dma_before = n_dma_gnt;
        fork
            begin @(posedge clk); #1; cpu_access(0, 64'h20, 64'h0); end
            begin
                @(posedge clk); @(posedge clk); #1;
                dma_req = 1'b1; dma_we = 1'b1; dma_addr = 64'h77; dma_wdata = 64'h99;
                @(posedge clk); @(negedge clk);
                dma_req = 1'b0;
            end
        join
        idle_cycles(6);
        chk("dropped_req_no_gnt", 64'(n_dma_gnt - dma_before), 64'd0);

        // Reset, then both ports hold requests across four grants
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk("rst2_busy", {63'd0, busy}, 64'd0);
        idle_cycles(2);
        reset = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
        exp_push(0, 1, 64'h40, 64'hC0, 64'h0, -1);
        exp_push(1, 1, 64'h50, 64'hD0, 64'h0, 1);
        exp_push(0, 1, 64'h40, 64'hC0, 64'h0, 1);
        exp_push(1, 1, 64'h50, 64'hD0, 64'h0, 1);
`else
        exp_push(0, 1, 64'h40, 64'hC0, 64'h0, -1);
        exp_push(0, 1, 64'h40, 64'hC0, 64'h0, 1);
        exp_push(0, 1, 64'h40, 64'hC0, 64'h0, 1);
        exp_push(0, 1, 64'h40, 64'hC0, 64'h0, 1);
`endif
        @(posedge clk); #1;
        cpu_req = 1; cpu_we = 1; cpu_addr = 64'h40; cpu_wdata = 64'hC0;
        dma_req = 1; dma_we = 1; dma_addr = 64'h50; dma_wdata = 64'hD0;
        k = 0;
        for (int i = 0; i < 40 && k < 4; i++) begin
            @(negedge clk);
            if (cpu_gnt || dma_gnt) k++;
        end
        cpu_req = 0; dma_req = 0;
        chk("tie_grant_count", 64'(k), 64'd4);
        idle_cycles(6);
        chk("sb_gnt_drain", 64'(exp_gnt.size()), 64'd0);
        chk("sb_rd_drain", 64'(pend.size()), 64'd0);

        // RD_LAT=3 instance: latency, address hold, then reset mid-read
        l3_reset = 1'b1;
        @(posedge clk); #1;
        l3_cpu_req = 1; l3_cpu_we = 0; l3_cpu_addr = 64'h08;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin @(negedge clk); got = l3_cpu_gnt; end
        l3_cpu_req = 0;
        l3_gnt_cyc = cyc;
        chk("l3_gnt", {63'd0, got}, 64'd1);
        @(negedge clk);
        chk("l3_rdwait_addr", l3_mem_addr, 64'h08);
        chk("l3_rdwait_wr", {63'd0, l3_mem_wr}, 64'd0);
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin @(negedge clk); got = l3_cpu_rvalid; end
        chk("l3_rvalid_latency", got ? 64'(cyc - l3_gnt_cyc) : 64'hFFFF, 64'd4);
        chk("l3_rdata", l3_cpu_rdata, 64'hABCD);

        @(posedge clk); #1;
        l3_cpu_req = 1;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin @(negedge clk); got = l3_cpu_gnt; end
        l3_cpu_req = 0;
        @(negedge clk);
        l3_reset = 1'b0;
        #1;
        chk("l3_abort_busy", {63'd0, l3_busy}, 64'd0);
        chk("l3_abort_gnt", {62'd0, l3_cpu_gnt, l3_dma_gnt}, 64'd0);
        chk("l3_abort_rvalid", {62'd0, l3_cpu_rvalid, l3_dma_rvalid}, 64'd0);
        chk("l3_abort_mem_wr", {63'd0, l3_mem_wr}, 64'd0);
        chk("l3_abort_mem_addr", l3_mem_addr, 64'd0);
        chk("l3_abort_rdata", l3_cpu_rdata, 64'd0);
        @(negedge clk);
        l3_reset = 1'b1;
        k = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (l3_cpu_rvalid || l3_dma_rvalid) k++;
        end
        chk("l3_no_rvalid_after_reset", 64'(k), 64'd0);
        chk("l3_idle_busy", {63'd0, l3_busy}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
